bus_share_mux: RTL and testbench

BUS_SHARE_MUX -- requirements
Module: bus_share_mux

---
 rtl/bus_share_mux.sv | 165 ++++++++++++++++
 tb/tb_bus_share_mux.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_share_mux.sv
// bus_share_mux: funnels N arbitrated clients onto one shared request/response bus.
// Ports: ipClk/Reset; ipGrant/opRequest arbiter link; ipClient*/opClient* per-client side;
//   opBus*/ipBusReady request channel; ipBusReadValid/ipBusReadData read response.
module bus_share_mux #(
  parameter int N       = 4,
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            ipClk,
  input  logic            Reset,
  input  logic [N-1:0]    ipGrant,
  output logic [N-1:0]    opRequest,
  input  logic [N-1:0]    ipClientValid,
  input  logic [N-1:0]    ipClientWrite,
  input  logic [N*AW-1:0] ipClientAddress,
  input  logic [N*DW-1:0] ipClientWriteData,
  output logic [N-1:0]    opClientDone,
  output logic            opClientError,
  output logic [DW-1:0]   opClientReadData,
  output logic            opBusValid,
  output logic            opBusWrite,
  output logic [AW-1:0]   opBusAddress,
  output logic [DW-1:0]   opBusWriteData,
  input  logic            ipBusReady,
  input  logic            ipBusReadValid,
  input  logic [DW-1:0]   ipBusReadData
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_RELEASE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            busValid_q, busValid_d;
  logic            busWrite_q, busWrite_d;
  logic [AW-1:0]   busAddr_q, busAddr_d;
  logic [DW-1:0]   busData_q, busData_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    done_q, done_d;
  logic            err_q, err_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic [IW-1:0]   gidx;
  logic            gok;
  logic [N-1:0]    mask;
  logic [N-1:0]    idxHot;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++)
      if (ipGrant[i]) gidx = IW'(i);
  end

  // Only a clean one-hot grant to a client that actually wants the bus counts.
  assign gok = $onehot(ipGrant) && |(ipGrant & ipClientValid);

  assign idxHot = N'(1) << idx_q;

  // Hiding the owner's request while finishing lets the arbiter rotate.
  assign mask = (state_q == S_DONE || state_q == S_RELEASE) ? idxHot : '0;
  assign opRequest = ipClientValid & ~mask;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    busValid_d = busValid_q;
    busWrite_d = busWrite_q;
    busAddr_d  = busAddr_q;
    busData_d  = busData_q;
    cnt_d      = cnt_q;
    done_d     = '0;
    err_d      = err_q;
    rdata_d    = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (gok) begin
          state_d    = S_ISSUE;
          idx_d      = gidx;
          busValid_d = 1'b1;
          busWrite_d = ipClientWrite[gidx];
          busAddr_d  = ipClientAddress[gidx*AW +: AW];
          busData_d  = ipClientWriteData[gidx*DW +: DW];
        end
      end
      S_ISSUE: begin
        if (ipBusReady) begin
          busValid_d = 1'b0;
          busWrite_d = 1'b0;
          busAddr_d  = '0;
          busData_d  = '0;
          cnt_d      = '0;
          if (busWrite_q) begin
            state_d = S_DONE;
            done_d  = idxHot;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Read data beats the timeout when both land together.
        if (ipBusReadValid) begin
          rdata_d = ipBusReadData;
          err_d   = 1'b0;
          state_d = S_DONE;
          done_d  = idxHot;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
          done_d  = idxHot;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!ipGrant[idx_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ipClk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      busValid_q <= 1'b0;
      busWrite_q <= 1'b0;
      busAddr_q  <= '0;
      busData_q  <= '0;
      cnt_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      busValid_q <= busValid_d;
      busWrite_q <= busWrite_d;
      busAddr_q  <= busAddr_d;
      busData_q  <= busData_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign opBusValid       = busValid_q;
  assign opBusWrite       = busWrite_q;
  assign opBusAddress     = busAddr_q;
  assign opBusWriteData   = busData_q;
  assign opClientDone     = done_q;
  assign opClientError    = err_q;
  assign opClientReadData = rdata_q;

endmodule

// File: tb/tb_bus_share_mux.sv
// tb_bus_share_mux: directed bench for bus_share_mux with a completion scoreboard.
// Includes a small round-robin arbiter model for the rotation scenario.
module tb_bus_share_mux;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 4;

  logic            ipClk = 1'b0;
  logic            Reset;
  logic [N-1:0]    ipGrant, man_grant, opRequest;
  logic [N-1:0]    ipClientValid, ipClientWrite, opClientDone;
  logic [N*AW-1:0] ipClientAddress;
  logic [N*DW-1:0] ipClientWriteData;
  logic            opClientError;
  logic [DW-1:0]   opClientReadData;
  logic            opBusValid, opBusWrite;
  logic [AW-1:0]   opBusAddress;
  logic [DW-1:0]   opBusWriteData;
  logic            ipBusReady, ipBusReadValid;
  logic [DW-1:0]   ipBusReadData;

  typedef struct {
    logic [N-1:0]  done;
    logic          err;
    logic [DW-1:0] rd;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int errors = 0;
  int checks = 0;

  logic          arb_en;
  logic [N-1:0]  arb_g, ng;
  int            last, nl, c;

  always #5 ipClk = ~ipClk;

  assign ipGrant = arb_en ? arb_g : man_grant;

  bus_share_mux #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .ipClk(ipClk), .Reset(Reset),
    .ipGrant(ipGrant), .opRequest(opRequest),
    .ipClientValid(ipClientValid), .ipClientWrite(ipClientWrite),
    .ipClientAddress(ipClientAddress), .ipClientWriteData(ipClientWriteData),
    .opClientDone(opClientDone), .opClientError(opClientError),
    .opClientReadData(opClientReadData),
    .opBusValid(opBusValid), .opBusWrite(opBusWrite),
    .opBusAddress(opBusAddress), .opBusWriteData(opBusWriteData),
    .ipBusReady(ipBusReady), .ipBusReadValid(ipBusReadValid),
    .ipBusReadData(ipBusReadData)
  );

  // Round-robin arbiter: holds a grant while the request stays up.
  always @(posedge ipClk) begin
    if (Reset || !arb_en) begin
      arb_g <= '0;
      last  <= N - 1;
    end else if ((arb_g & opRequest) == '0) begin
      ng = '0;
      nl = last;
      for (int k = 1; k <= N; k++) begin
        c = (last + k) % N;
        if (ng == '0 && opRequest[c]) begin
          ng[c] = 1'b1;
          nl    = c;
        end
      end
      arb_g <= ng;
      last  <= nl;
    end
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge ipClk);
    #1;
  endtask

  task automatic push(logic [N-1:0] d, logic er, logic [DW-1:0] rd);
    exp_t x;
    x.done = d;
    x.err  = er;
    x.rd   = rd;
    sb.push_back(x);
  endtask

  task automatic set_client(int i, logic v, logic w,
                            logic [AW-1:0] a, logic [DW-1:0] d);
    ipClientValid[i]              = v;
    ipClientWrite[i]              = w;
    ipClientAddress[i*AW +: AW]   = a;
    ipClientWriteData[i*DW +: DW] = d;
  endtask

  task automatic drain(string tag, int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_drain"}, 64'(sb.size()), 64'd0);
  endtask

  // Scoreboard: every done pulse must match the oldest expectation.
  always @(negedge ipClk) begin
    if (Reset === 1'b0) begin
      if (opClientDone !== '0) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_done", 64'(opClientDone), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_done", 64'(opClientDone), 64'(e.done));
          chk("sb_err", 64'(opClientError), 64'(e.err));
          chk("sb_rdata", 64'(opClientReadData), 64'(e.rd));
        end
      end
      if (opBusValid === 1'b0)
        chk("bus_idle_zero",
            64'({opBusWrite, opBusAddress, opBusWriteData}), 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    arb_en = 1'b0;
    man_grant = '0;
    ipClientValid = '0;
    ipClientWrite = '0;
    ipClientAddress = '0;
    ipClientWriteData = '0;
    ipBusReady = 1'b0;
    ipBusReadValid = 1'b0;
    ipBusReadData = '0;
    repeat (3) step();
    chk("rst_busvalid", 64'(opBusValid), 64'd0);
    chk("rst_bus", 64'({opBusWrite, opBusAddress, opBusWriteData}), 64'd0);
    chk("rst_done", 64'(opClientDone), 64'd0);
    chk("rst_err", 64'(opClientError), 64'd0);
    chk("rst_rdata", 64'(opClientReadData), 64'd0);

    // Write from client 2, granted the first cycle out of reset.
    set_client(2, 1'b1, 1'b1, 16'h0010, 32'hDEADBEEF);
    ipBusReady = 1'b1;
    Reset = 1'b0;
    man_grant = 4'b0100;
    push(4'b0100, 1'b0, 32'h0);
    step();
    chk("wr_busvalid", 64'(opBusValid), 64'd1);
    chk("wr_buswrite", 64'(opBusWrite), 64'd1);
    chk("wr_addr", 64'(opBusAddress), 64'h10);
    chk("wr_data", 64'(opBusWriteData), 64'hDEADBEEF);
    chk("wr_done_early", 64'(opClientDone), 64'd0);
    chk("wr_req_issue", 64'(opRequest), 64'b0100);
    step();
    chk("wr_done_t2", 64'(opClientDone), 64'b0100);
    chk("wr_req_done", 64'(opRequest[2]), 64'd0);
    chk("wr_rdata_kept", 64'(opClientReadData), 64'd0);
    man_grant = '0;
    step();
    chk("wr_done_once", 64'(opClientDone), 64'd0);
    chk("wr_req_release", 64'(opRequest[2]), 64'd0);
    set_client(2, 1'b0, 1'b0, '0, '0);
    step();

    // Read from client 0 with a slow bus and a stray pre-accept response.
    set_client(0, 1'b1, 1'b0, 16'h0004, '0);
    ipBusReady = 1'b0;
    man_grant = 4'b0001;
    push(4'b0001, 1'b0, 32'h12345678);
    step();
    chk("rd_busvalid", 64'(opBusValid), 64'd1);
    chk("rd_buswrite", 64'(opBusWrite), 64'd0);
    chk("rd_addr", 64'(opBusAddress), 64'h4);
    ipBusReadValid = 1'b1;
    ipBusReadData = 32'hBAD0BAD0;
    step();
    chk("rd_hold1", 64'(opBusValid), 64'd1);
    ipBusReadValid = 1'b0;
    step();
    chk("rd_hold2", 64'(opBusValid), 64'd1);
    step();
    chk("rd_hold3", 64'(opBusValid), 64'd1);
    chk("rd_addr_hold", 64'(opBusAddress), 64'h4);
    ipBusReady = 1'b1;
    step();
    chk("rd_accepted", 64'(opBusValid), 64'd0);
    set_client(0, 1'b0, 1'b0, '0, '0);
    step();
    ipBusReadValid = 1'b1;
    ipBusReadData = 32'h12345678;
    step();
    chk("rd_done", 64'(opClientDone), 64'b0001);
    chk("rd_data", 64'(opClientReadData), 64'h12345678);
    chk("rd_err", 64'(opClientError), 64'd0);
    ipBusReadValid = 1'b0;
    man_grant = '0;
    repeat (2) step();

    // Timeout on client 1 after exactly TO wait cycles.
    set_client(1, 1'b1, 1'b0, 16'h0008, '0);
    man_grant = 4'b0010;
    push(4'b0010, 1'b1, 32'h0);
    step();
    chk("to_busvalid", 64'(opBusValid), 64'd1);
    for (int w = 0; w < TO; w++) begin
      step();
      chk("to_wait_nodone", 64'(opClientDone), 64'd0);
    end
    step();
    chk("to_done", 64'(opClientDone), 64'b0010);
    chk("to_err", 64'(opClientError), 64'd1);
    chk("to_rdata", 64'(opClientReadData), 64'd0);
    man_grant = '0;
    step();
    chk("to_err_held", 64'(opClientError), 64'd1);
    set_client(1, 1'b0, 1'b0, '0, '0);
    step();

    // Response on the last wait cycle beats the timeout and clears error.
    set_client(1, 1'b1, 1'b0, 16'h000C, '0);
    man_grant = 4'b0010;
    push(4'b0010, 1'b0, 32'hCAFEF00D);
    step();
    repeat (TO - 1) step();
    step();
    ipBusReadValid = 1'b1;
    ipBusReadData = 32'hCAFEF00D;
    step();
    chk("tie_done", 64'(opClientDone), 64'b0010);
    chk("tie_err", 64'(opClientError), 64'd0);
    chk("tie_rdata", 64'(opClientReadData), 64'hCAFEF00D);
    ipBusReadValid = 1'b0;
    man_grant = '0;
    step();
    set_client(1, 1'b0, 1'b0, '0, '0);
    step();

    // Illegal grants are ignored, then a clean grant to client 3.
    set_client(0, 1'b1, 1'b1, 16'h0020, 32'h1);
    set_client(1, 1'b1, 1'b1, 16'h0024, 32'h2);
    man_grant = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("ill_multihot", 64'(opBusValid), 64'd0);
    end
    man_grant = 4'b0100;
    step();
    step();
    chk("ill_novalid", 64'(opBusValid), 64'd0);
    man_grant = 4'b0000;
    step();
    chk("ill_zero", 64'(opBusValid), 64'd0);
    set_client(0, 1'b0, 1'b0, '0, '0);
    set_client(1, 1'b0, 1'b0, '0, '0);
    set_client(3, 1'b1, 1'b1, 16'h0030, 32'h55);
    man_grant = 4'b1000;
    push(4'b1000, 1'b0, 32'hCAFEF00D);
    step();
    chk("ill_ok_valid", 64'(opBusValid), 64'd1);
    chk("ill_ok_addr", 64'(opBusAddress), 64'h30);
    chk("ill_ok_data", 64'(opBusWriteData), 64'h55);
    step();
    chk("ill_ok_done", 64'(opClientDone), 64'b1000);
    man_grant = '0;
    step();
    set_client(3, 1'b0, 1'b0, '0, '0);
    step();

    // Reset in the middle of a read abandons it silently.
    set_client(0, 1'b1, 1'b0, 16'h0040, '0);
    man_grant = 4'b0001;
    step();
    step();
    Reset = 1'b1;
    man_grant = '0;
    set_client(0, 1'b0, 1'b0, '0, '0);
    step();
    chk("mid_rst_busvalid", 64'(opBusValid), 64'd0);
    chk("mid_rst_bus",
        64'({opBusWrite, opBusAddress, opBusWriteData}), 64'd0);
    chk("mid_rst_done", 64'(opClientDone), 64'd0);
    chk("mid_rst_err", 64'(opClientError), 64'd0);
    chk("mid_rst_rdata", 64'(opClientReadData), 64'd0);
    Reset = 1'b0;
    step();
    ipBusReadValid = 1'b1;
    ipBusReadData = 32'h77;
    step();
    chk("mid_rst_late_rv", 64'(opClientDone), 64'd0);
    ipBusReadValid = 1'b0;
    step();
    chk("mid_rst_late_rv2", 64'(opClientDone), 64'd0);
    chk("mid_rst_rdata2", 64'(opClientReadData), 64'd0);

    // All four clients contend through the round-robin arbiter.
    for (int i = 0; i < N; i++)
      set_client(i, 1'b1, 1'b1, AW'(i * 16'h100), DW'(32'hA0 + i));
    push(4'b0001, 1'b0, 32'h0);
    push(4'b0010, 1'b0, 32'h0);
    push(4'b0100, 1'b0, 32'h0);
    push(4'b1000, 1'b0, 32'h0);
    push(4'b0001, 1'b0, 32'h0);
    arb_en = 1'b1;
    drain("arb", 300);
    arb_en = 1'b0;
    ipClientValid = '0;
    repeat (6) step();
    chk("arb_quiet", 64'(opBusValid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
